// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared flash command set, status bit positions and sequencer state types
package flash_pkg;

    localparam logic [7:0] CMD_CLR_SR   = 8'h50;
    localparam logic [7:0] CMD_PROG     = 8'h40;
    localparam logic [7:0] CMD_ERASE    = 8'h20;
    localparam logic [7:0] CMD_CONFIRM  = 8'hD0;
    localparam logic [7:0] CMD_RD_SR    = 8'h70;
    localparam logic [7:0] CMD_RD_ARRAY = 8'hFF;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPP_ERR   = 3;
    localparam int SR_LOCK_ERR  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WSETUP,
        ST_WLOW,
        ST_WHOLD,
        ST_POLL_PRE,
        ST_PLOW,
        ST_PPOST
    } bus_state_e;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_CMD,
        SQ_POLL,
        SQ_FIN
    } seq_state_e;

    // Bus word for the four writes that precede status polling.
    function automatic logic [15:0] seq_word(input logic op, input logic [1:0] step,
                                             input logic [15:0] wdata);
        logic [7:0] cmd;
        cmd = CMD_RD_SR;
        case (step)
            2'd0:    cmd = CMD_CLR_SR;
            2'd1:    cmd = op ? CMD_ERASE : CMD_PROG;
            2'd2:    cmd = CMD_CONFIRM;
            default: cmd = CMD_RD_SR;
        endcase
        if (step == 2'd2 && !op) begin
            return {wdata[7:0], wdata[15:8]};
        end
        return {8'h00, cmd};
    endfunction

    function automatic logic sr_failed(input logic [7:0] sr);
        return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPP_ERR] | sr[SR_LOCK_ERR];
    endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// rtl/flash_bus_cycle.sv - one flash write cycle or one status read per start/ack handshake
module flash_bus_cycle
    import flash_pkg::*;
#(
    parameter int WE_CYCLES = 2,
    parameter int RD_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        read_i,
    input  logic [15:0] wr_data_i,
    input  logic [7:0]  rd_bus_i,
    output logic        ack_o,
    output logic        idle_o,
    output logic [7:0]  rd_data_o,
    output logic        we_n_o,
    output logic        oe_n_o,
    output logic        data_oe_o,
    output logic [15:0] data_o
);

    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);
    localparam logic [3:0] RD_LAST = 4'(RD_CYCLES - 1);

    bus_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] wr_q, wr_d;
    logic [7:0]  rd_q, rd_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    wr_d    = wr_data_i;
                    state_d = read_i ? ST_POLL_PRE : ST_WSETUP;
                end
            end
            ST_WSETUP: begin
                cnt_d   = '0;
                state_d = ST_WLOW;
            end
            ST_WLOW: begin
                if (cnt_q == WE_LAST) begin
                    state_d = ST_WHOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WHOLD:    state_d = ST_IDLE;
            ST_POLL_PRE: begin
                cnt_d   = '0;
                state_d = ST_PLOW;
            end
            ST_PLOW: begin
                // Sample on the last oe-low cycle so the device has had the full access time.
                if (cnt_q == RD_LAST) begin
                    rd_d    = rd_bus_i;
                    state_d = ST_PPOST;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_PPOST: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_o     = (state_q == ST_WHOLD) || (state_q == ST_PPOST);
        idle_o    = (state_q == ST_IDLE);
        we_n_o    = (state_q != ST_WLOW);
        oe_n_o    = (state_q != ST_PLOW);
        data_oe_o = (state_q == ST_WSETUP) || (state_q == ST_WLOW) || (state_q == ST_WHOLD);
        data_o    = wr_q;
        rd_data_o = rd_q;
    end

endmodule

// File: rtl/flash_prog.sv
// rtl/flash_prog.sv - word program / block erase sequencer for a parallel NOR flash
module flash_prog
    import flash_pkg::*;
#(
    parameter int          WE_CYCLES = 2,
    parameter int          RD_CYCLES = 3,
    parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        op,
    input  logic [22:1] addr,
    input  logic [15:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic        flash_ce_n,
    output logic        flash_we_n,
    output logic        flash_oe_n,
    output logic        flash_rp_n,
    output logic        flash_byte_n,
    output logic        flash_vpen,
    output logic [22:1] flash_addr,
    inout  wire  [15:0] flash_data
);

    seq_state_e  seq_q, seq_d;
    logic [1:0]  step_q, step_d;
    logic        op_q, op_d;
    logic [22:1] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  status_q, status_d;
    logic [23:0] polls_q, polls_d;
    logic        fail_q, fail_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        bus_start, bus_read, bus_ack, bus_idle;
    logic [15:0] bus_wdata, bus_dout;
    logic [7:0]  bus_rdata;
    logic        data_oe;

    flash_bus_cycle #(
        .WE_CYCLES (WE_CYCLES),
        .RD_CYCLES (RD_CYCLES)
    ) u_bus (
        .clk       (clk),
        .rst       (rst),
        .start_i   (bus_start),
        .read_i    (bus_read),
        .wr_data_i (bus_wdata),
        .rd_bus_i  (flash_data[7:0]),
        .ack_o     (bus_ack),
        .idle_o    (bus_idle),
        .rd_data_o (bus_rdata),
        .we_n_o    (flash_we_n),
        .oe_n_o    (flash_oe_n),
        .data_oe_o (data_oe),
        .data_o    (bus_dout)
    );

    assign flash_data = data_oe ? bus_dout : 16'hzzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q    <= SQ_IDLE;
            step_q   <= '0;
            op_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            status_q <= '0;
            polls_q  <= '0;
            fail_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            seq_q    <= seq_d;
            step_q   <= step_d;
            op_q     <= op_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            status_q <= status_d;
            polls_q  <= polls_d;
            fail_q   <= fail_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        seq_d    = seq_q;
        step_d   = step_q;
        op_d     = op_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        status_d = status_q;
        polls_d  = polls_q;
        fail_d   = fail_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        case (seq_q)
            SQ_IDLE: begin
                if (req) begin
                    seq_d   = SQ_CMD;
                    step_d  = '0;
                    op_d    = op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    polls_d = '0;
                    fail_d  = 1'b0;
                end
            end
            SQ_CMD: begin
                if (bus_ack) begin
                    if (step_q == 2'd3) begin
                        seq_d = SQ_POLL;
                    end else begin
                        step_d = step_q + 2'd1;
                    end
                end
            end
            SQ_POLL: begin
                if (bus_ack) begin
                    polls_d  = polls_q + 24'd1;
                    status_d = bus_rdata;
                    if (bus_rdata[SR_READY]) begin
                        fail_d = sr_failed(bus_rdata);
                        seq_d  = SQ_FIN;
                    end else if (polls_q + 24'd1 >= TIMEOUT) begin
                        // A device that never reports ready is reported as a failure with a cleared status.
                        status_d = 8'h00;
                        fail_d   = 1'b1;
                        seq_d    = SQ_FIN;
                    end
                end
            end
            SQ_FIN: begin
                if (bus_ack) begin
                    seq_d   = SQ_IDLE;
                    done_d  = !fail_q;
                    error_d = fail_q;
                end
            end
            default: seq_d = SQ_IDLE;
        endcase
    end

    always_comb begin
        busy         = (seq_q != SQ_IDLE);
        flash_ce_n   = !busy;
        bus_start    = busy && bus_idle;
        bus_read     = (seq_q == SQ_POLL);
        bus_wdata    = (seq_q == SQ_FIN) ? {8'h00, CMD_RD_ARRAY} : seq_word(op_q, step_q, wdata_q);
        done         = done_q;
        error        = error_q;
        status       = status_q;
        flash_addr   = addr_q;
        flash_rp_n   = 1'b1;
        flash_byte_n = 1'b1;
        flash_vpen   = 1'b1;
    end

endmodule

// File: tb/tb_flash_prog.sv
// tb/tb_flash_prog.sv - directed bench for flash_prog with a status-register flash model
module tb_flash_prog;

    localparam int WE_CYC = 2;

    logic        clk = 1'b0;
    logic        rst, req, op;
    logic [22:1] addr;
    logic [15:0] wdata;
    logic        busy, done, error;
    logic [7:0]  status;
    logic        flash_ce_n, flash_we_n, flash_oe_n, flash_rp_n, flash_byte_n, flash_vpen;
    logic [22:1] flash_addr;
    wire  [15:0] flash_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_log[$];
    int          polls = 0, done_cnt = 0, err_cnt = 0, we_low = 0;
    logic        prev_we = 1'b1, prev_oe = 1'b1;
    int          poll_base = 0, wr_base = 0, done_base = 0, err_base = 0;
    logic [7:0]  sr_tab[4];
    int          sr_n = 1;
    logic [7:0]  sr_cur;

    flash_prog #(
        .WE_CYCLES (WE_CYC),
        .RD_CYCLES (3),
        .TIMEOUT   (24'd5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .op           (op),
        .addr         (addr),
        .wdata        (wdata),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .status       (status),
        .flash_ce_n   (flash_ce_n),
        .flash_we_n   (flash_we_n),
        .flash_oe_n   (flash_oe_n),
        .flash_rp_n   (flash_rp_n),
        .flash_byte_n (flash_byte_n),
        .flash_vpen   (flash_vpen),
        .flash_addr   (flash_addr),
        .flash_data   (flash_data)
    );

    always #5 clk = ~clk;

    // Flash model: k-th poll of the current operation returns sr_tab[k], last entry repeats.
    always_comb begin : sr_sel
        int k;
        k = polls - poll_base;
        if (k > sr_n - 1) k = sr_n - 1;
        if (k < 0) k = 0;
        sr_cur = sr_tab[k[1:0]];
    end

    assign flash_data = flash_oe_n ? 16'hzzzz : {8'h00, sr_cur};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            we_low  = 0;
            prev_we = 1'b1;
            prev_oe = 1'b1;
        end else begin
            check("strobe_overlap", 32'(flash_we_n | flash_oe_n), 32'd1);
            check("drive_during_oe", 32'(dut.data_oe & ~flash_oe_n), 32'd0);
            if (!flash_we_n) begin
                we_low++;
            end else if (!prev_we) begin
                check("we_width", 32'(we_low), 32'(WE_CYC));
                wr_log.push_back(flash_data);
                we_low = 0;
            end
            if (flash_oe_n && !prev_oe) polls++;
            if (done) done_cnt++;
            if (error) err_cnt++;
            prev_we = flash_we_n;
            prev_oe = flash_oe_n;
        end
    end

    task automatic start_op(input logic o, input logic [22:1] a, input logic [15:0] d);
        @(negedge clk);
        #1;
        poll_base = polls;
        wr_base   = wr_log.size();
        done_base = done_cnt;
        err_base  = err_cnt;
        op = o; addr = a; wdata = d; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_finish(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) check({tag, "_finish_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] exp_w[5]);
        check({tag, "_nwrites"}, 32'(wr_log.size() - wr_base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (wr_base + i < wr_log.size())
                check($sformatf("%s_w%0d", tag, i), 32'(wr_log[wr_base + i]), 32'(exp_w[i]));
        end
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; op = 1'b0; addr = '0; wdata = '0;
        sr_tab = '{8'h00, 8'h00, 8'h80, 8'h80};
        sr_n = 3;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_status", 32'(status), 32'h00);
        check("rst_ce_n", 32'(flash_ce_n), 32'd1);
        check("rst_we_n", 32'(flash_we_n), 32'd1);
        check("rst_oe_n", 32'(flash_oe_n), 32'd1);
        check("rst_addr", 32'(flash_addr), 32'd0);
        check("rst_data_oe", 32'(dut.data_oe), 32'd0);
        check("tied_pins", 32'({flash_rp_n, flash_byte_n, flash_vpen}), 32'h7);
        rst = 1'b0;

        // Word program: two not-ready polls then ready.
        start_op(1'b0, 22'h000100, 16'h1234);
        check("prog_busy", 32'(busy), 32'd1);
        check("prog_ce_n", 32'(flash_ce_n), 32'd0);
        check("prog_addr", 32'(flash_addr), 32'h000100);
        wait_finish("prog");
        check("prog_done", 32'(done), 32'd1);
        check("prog_busy_low", 32'(busy), 32'd0);
        check("prog_status", 32'(status), 32'h80);
        check("prog_ce_idle", 32'(flash_ce_n), 32'd1);
        @(negedge clk);
        #1;
        check("prog_done_pulse", 32'(done), 32'd0);
        check("prog_polls", 32'(polls - poll_base), 32'd3);
        check("prog_ndone", 32'(done_cnt - done_base), 32'd1);
        check("prog_nerr", 32'(err_cnt - err_base), 32'd0);
        check_writes("prog", '{16'h0050, 16'h0040, 16'h3412, 16'h0070, 16'h00FF});

        // Block erase reporting an erase error.
        sr_tab = '{8'hA0, 8'hA0, 8'hA0, 8'hA0};
        sr_n = 1;
        start_op(1'b1, 22'h200000, 16'hFFFF);
        check("erase_addr", 32'(flash_addr), 32'h200000);
        wait_finish("erase");
        check("erase_error", 32'(error), 32'd1);
        check("erase_busy_low", 32'(busy), 32'd0);
        check("erase_status", 32'(status), 32'hA0);
        @(negedge clk);
        #1;
        check("erase_ndone", 32'(done_cnt - done_base), 32'd0);
        check("erase_nerr", 32'(err_cnt - err_base), 32'd1);
        check("erase_polls", 32'(polls - poll_base), 32'd1);
        check_writes("erase", '{16'h0050, 16'h0020, 16'h00D0, 16'h0070, 16'h00FF});

        // Status stuck not-ready: abort after TIMEOUT polls.
        sr_tab = '{8'h00, 8'h00, 8'h00, 8'h00};
        start_op(1'b0, 22'h000004, 16'h0000);
        wait_finish("tmo");
        check("tmo_error", 32'(error), 32'd1);
        check("tmo_status", 32'(status), 32'h00);
        @(negedge clk);
        #1;
        check("tmo_polls", 32'(polls - poll_base), 32'd5);
        check("tmo_ndone", 32'(done_cnt - done_base), 32'd0);
        check_writes("tmo", '{16'h0050, 16'h0040, 16'h0000, 16'h0070, 16'h00FF});

        // Second req while busy must be ignored.
        sr_tab = '{8'h80, 8'h80, 8'h80, 8'h80};
        start_op(1'b0, 22'h000200, 16'hABCD);
        repeat (6) @(negedge clk);
        op = 1'b1; wdata = 16'h5555; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_finish("dup");
        repeat (60) @(negedge clk);
        #1;
        check("dup_ndone", 32'(done_cnt - done_base), 32'd1);
        check("dup_nerr", 32'(err_cnt - err_base), 32'd0);
        check("dup_busy", 32'(busy), 32'd0);
        check_writes("dup", '{16'h0050, 16'h0040, 16'hCDAB, 16'h0070, 16'h00FF});

        // Reset during the we-low phase of the data write.
        start_op(1'b0, 22'h00ABCD, 16'hBEEF);
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                #1;
                n++;
            end while (!((wr_log.size() - wr_base == 2) && !flash_we_n) && n < 200);
            check("abort_reached_wlow", 32'(flash_we_n), 32'd0);
        end
        #1 rst = 1'b1;
        #1;
        check("abort_we_n", 32'(flash_we_n), 32'd1);
        check("abort_data_oe", 32'(dut.data_oe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ce_n", 32'(flash_ce_n), 32'd1);
        check("abort_status", 32'(status), 32'h00);
        check("abort_addr", 32'(flash_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_op(1'b0, 22'h000010, 16'h0102);
        wait_finish("restart");
        check("restart_done", 32'(done), 32'd1);
        @(negedge clk);
        #1;
        check_writes("restart", '{16'h0050, 16'h0040, 16'h0201, 16'h0070, 16'h00FF});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
